// File: rtl/v810_bus_pkg.sv
// Shared types and constants for the v810 data-bus responder.
package v810_bus_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        MR_IDLE = 2'd0,
        MR_WAIT = 2'd1,
        MR_ACK  = 2'd2
    } mem_resp_state_t;

    localparam logic [1:0] ST_DATA_RD = 2'b00;
    localparam logic [1:0] ST_DATA_WR = 2'b01;
    localparam logic [1:0] ST_IO      = 2'b10;
    localparam logic [1:0] ST_SYSTEM  = 2'b11;

    // Active-low byte enables to an active-high lane mask, write only.
    function automatic logic [BE_W-1:0] lane_we(input logic rw, input logic [BE_W-1:0] ben);
        return rw ? '0 : ~ben;
    endfunction

endpackage

// File: rtl/v810_bram_be.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module v810_bram_be
    import v810_bus_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [BE_W-1:0]   we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int i = 0; i < BE_W; i++) begin
                if (we_i[i]) begin
                    mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/v810_mem_resp.sv
// Wait-state data-bus responder for v810_exec backed by a byte-lane RAM.
// Optional window check enabled by defining V810_MEM_RESP_RANGE_CHECK_EN.
module v810_mem_resp
    import v810_bus_pkg::*;
#(
    parameter int          AW   = 10,
    parameter int          WAIT = 0,
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              CE,
    input  logic [31:0]       DA,
    input  logic [DATA_W-1:0] DD_O,
    input  logic [BE_W-1:0]   BEn,
    input  logic              MRQn,
    input  logic              RW,
    input  logic [1:0]        ST,
    output logic [DATA_W-1:0] DD_I,
    output logic              READYn,
    output logic              ERR
);

    localparam logic [3:0] WAIT_LD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    mem_resp_state_t   state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW-1:0]     addr_q;
    logic              rw_q;
    logic [BE_W-1:0]   ben_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        st_q;
    logic              oow_q;

    logic              sample, go_ack, oow_in;
    logic [AW-1:0]     cur_addr;
    logic              cur_rw, cur_oow;
    logic [BE_W-1:0]   cur_ben;
    logic [DATA_W-1:0] cur_wdata;
    logic              ram_en;
    logic [BE_W-1:0]   ram_we;
    logic [DATA_W-1:0] ram_rdata;

`ifdef V810_MEM_RESP_RANGE_CHECK_EN
    assign oow_in = (DA[31:AW+2] != BASE[31:AW+2]);
    assign ERR    = (state_q == MR_ACK) && oow_q;
`else
    assign oow_in = 1'b0;
    assign ERR    = 1'b0;
`endif

    // A request is taken from IDLE, or from ACK on the edge that ends the strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sample  = 1'b0;
        go_ack  = 1'b0;
        case (state_q)
            MR_IDLE, MR_ACK: begin
                state_d = MR_IDLE;
                if (!MRQn) begin
                    sample = 1'b1;
                    if (WAIT == 0) begin
                        state_d = MR_ACK;
                        go_ack  = 1'b1;
                    end else begin
                        state_d = MR_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            MR_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = MR_ACK;
                    go_ack  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = MR_IDLE;
        endcase
    end

    // With no wait states the RAM access happens on the sampling edge itself.
    assign cur_addr  = sample ? DA[AW+1:2] : addr_q;
    assign cur_rw    = sample ? RW         : rw_q;
    assign cur_ben   = sample ? BEn        : ben_q;
    assign cur_wdata = sample ? DD_O       : wdata_q;
    assign cur_oow   = sample ? oow_in     : oow_q;

    assign ram_en = CE && !RES && go_ack;
    assign ram_we = cur_oow ? '0 : lane_we(cur_rw, cur_ben);

    v810_bram_be #(.AW(AW)) u_ram (
        .clk_i   (CLK),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (cur_addr),
        .wdata_i (cur_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= MR_IDLE;
            cnt_q   <= 4'd0;
        end else if (CE) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RES && CE && sample) begin
            addr_q  <= DA[AW+1:2];
            rw_q    <= RW;
            ben_q   <= BEn;
            wdata_q <= DD_O;
            st_q    <= ST;
            oow_q   <= oow_in;
        end
    end

    assign READYn = (state_q != MR_ACK);
    assign DD_I   = (state_q == MR_ACK && rw_q && !oow_q) ? ram_rdata : '0;

endmodule
